// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use stall, flush and memory-busy hold.
// Optional HAZ_STATS_EN adds saturating stall/flush bubble counters.
module id_ex_hazard_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ID_valid,
  input  logic [4:0]        ID_Rs,
  input  logic [4:0]        ID_Rt,
  input  logic              ID_UseRs,
  input  logic              ID_UseRt,
  input  logic [4:0]        ID_WR,
  input  logic              ID_RegWrite,
  input  logic              ID_MemRead,
  input  logic              ID_MemWrite,
  input  logic [CTRL_W-1:0] ID_Ctrl,
  input  logic [DATA_W-1:0] ID_RD1,
  input  logic [DATA_W-1:0] ID_RD2,
  input  logic [DATA_W-1:0] ID_Imm,
  input  logic              Flush,
  input  logic              Mem_Busy,
  output logic              EX_valid,
  output logic [4:0]        EX_Rs,
  output logic [4:0]        EX_Rt,
  output logic [4:0]        EX_WR,
  output logic              EX_RegWrite,
  output logic              EX_MemRead,
  output logic              EX_MemWrite,
  output logic [CTRL_W-1:0] EX_Ctrl,
  output logic [DATA_W-1:0] EX_RD1,
  output logic [DATA_W-1:0] EX_RD2,
  output logic [DATA_W-1:0] EX_Imm,
  output logic              PC_Write,
  output logic              IF_ID_Write
`ifdef HAZ_STATS_EN
  ,
  output logic [15:0]       Stall_Cnt,
  output logic [15:0]       Flush_Cnt
`endif
);

  typedef enum logic {RUN, HOLD} state_t;
  typedef enum logic [1:0] {
    EX_LOAD, EX_KEEP, EX_BUBBLE
  } ex_op_t;

  state_t state, state_n;
  ex_op_t ex_op;
  logic   flush_pend, flush_pend_n;
  logic   lu, eff_flush;

  assign lu = EX_valid & EX_MemRead & EX_RegWrite
            & (EX_WR != 5'd0) & ID_valid
            & ((ID_UseRs & (ID_Rs == EX_WR))
             | (ID_UseRt & (ID_Rt == EX_WR)));

  // a pending flush only exists while holding for memory
  assign eff_flush = Flush | ((state == HOLD) & flush_pend);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_n;
      flush_pend <= flush_pend_n;
    end
  end

  always_comb begin
    state_n      = RUN;
    flush_pend_n = flush_pend;
    ex_op        = EX_LOAD;
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    priority case (1'b1)
      Mem_Busy: begin
        state_n      = HOLD;
        flush_pend_n = flush_pend | Flush;
        ex_op        = EX_KEEP;
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
      end
      eff_flush: begin
        flush_pend_n = 1'b0;
        ex_op        = EX_BUBBLE;
      end
      lu: begin
        ex_op        = EX_BUBBLE;
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || ex_op == EX_BUBBLE) begin
      EX_valid    <= 1'b0;
      EX_Rs       <= '0;
      EX_Rt       <= '0;
      EX_WR       <= '0;
      EX_RegWrite <= 1'b0;
      EX_MemRead  <= 1'b0;
      EX_MemWrite <= 1'b0;
      EX_Ctrl     <= '0;
      EX_RD1      <= '0;
      EX_RD2      <= '0;
      EX_Imm      <= '0;
    end else if (ex_op == EX_LOAD) begin
      EX_valid    <= ID_valid;
      EX_Rs       <= ID_Rs;
      EX_Rt       <= ID_Rt;
      EX_WR       <= ID_WR;
      EX_RegWrite <= ID_RegWrite;
      EX_MemRead  <= ID_MemRead;
      EX_MemWrite <= ID_MemWrite;
      EX_Ctrl     <= ID_Ctrl;
      EX_RD1      <= ID_RD1;
      EX_RD2      <= ID_RD2;
      EX_Imm      <= ID_Imm;
    end
  end

`ifdef HAZ_STATS_EN
  logic stall_inc, flush_inc;

  assign stall_inc = ~Mem_Busy & ~eff_flush & lu;
  assign flush_inc = ~Mem_Busy & eff_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      Stall_Cnt <= '0;
      Flush_Cnt <= '0;
    end else begin
      if (stall_inc && Stall_Cnt != 16'hFFFF)
        Stall_Cnt <= Stall_Cnt + 16'd1;
      if (flush_inc && Flush_Cnt != 16'hFFFF)
        Flush_Cnt <= Flush_Cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Scoreboard bench for id_ex_hazard_reg.
// Reference model predicts EX register, write enables and counters.
module tb_id_ex_hazard_reg;

  typedef struct packed {
    logic        v;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wr;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [7:0]  ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
  } ex_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ID_valid, ID_UseRs, ID_UseRt;
  logic [4:0]  ID_Rs, ID_Rt, ID_WR;
  logic        ID_RegWrite, ID_MemRead, ID_MemWrite;
  logic [7:0]  ID_Ctrl;
  logic [31:0] ID_RD1, ID_RD2, ID_Imm;
  logic        Flush, Mem_Busy;
  logic        EX_valid, EX_RegWrite, EX_MemRead, EX_MemWrite;
  logic [4:0]  EX_Rs, EX_Rt, EX_WR;
  logic [7:0]  EX_Ctrl;
  logic [31:0] EX_RD1, EX_RD2, EX_Imm;
  logic        PC_Write, IF_ID_Write;
`ifdef HAZ_STATS_EN
  logic [15:0] Stall_Cnt, Flush_Cnt;
`endif

  id_ex_hazard_reg #(.DATA_W(32), .CTRL_W(8)) dut (
    .clk(clk), .rst(rst),
    .ID_valid(ID_valid),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
    .ID_WR(ID_WR),
    .ID_RegWrite(ID_RegWrite),
    .ID_MemRead(ID_MemRead),
    .ID_MemWrite(ID_MemWrite),
    .ID_Ctrl(ID_Ctrl),
    .ID_RD1(ID_RD1), .ID_RD2(ID_RD2), .ID_Imm(ID_Imm),
    .Flush(Flush), .Mem_Busy(Mem_Busy),
    .EX_valid(EX_valid),
    .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_WR(EX_WR),
    .EX_RegWrite(EX_RegWrite),
    .EX_MemRead(EX_MemRead),
    .EX_MemWrite(EX_MemWrite),
    .EX_Ctrl(EX_Ctrl),
    .EX_RD1(EX_RD1), .EX_RD2(EX_RD2), .EX_Imm(EX_Imm),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write)
`ifdef HAZ_STATS_EN
    ,
    .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt)
`endif
  );

  ex_t got;
  assign got = {EX_valid, EX_Rs, EX_Rt, EX_WR,
                EX_RegWrite, EX_MemRead, EX_MemWrite,
                EX_Ctrl, EX_RD1, EX_RD2, EX_Imm};

  ex_t  m;
  ex_t  q[$];
  logic pend;
  int   sc, fc;
  int   n_vec, n_err;
  logic last_we;

  task automatic idle();
    rst = 0; Flush = 0; Mem_Busy = 0;
    ID_valid = 0; ID_Rs = 0; ID_Rt = 0;
    ID_UseRs = 0; ID_UseRt = 0; ID_WR = 0;
    ID_RegWrite = 0; ID_MemRead = 0; ID_MemWrite = 0;
    ID_Ctrl = 0; ID_RD1 = 0; ID_RD2 = 0; ID_Imm = 0;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt,
                        input logic [4:0] wr, input logic rw,
                        input logic mr,
                        input logic [31:0] rd1,
                        input logic [31:0] rd2);
    ID_valid = 1; ID_Rs = rs; ID_Rt = rt;
    ID_UseRs = urs; ID_UseRt = urt; ID_WR = wr;
    ID_RegWrite = rw; ID_MemRead = mr; ID_MemWrite = 0;
    ID_Ctrl = 8'($urandom); ID_RD1 = rd1; ID_RD2 = rd2;
    ID_Imm = $urandom;
  endtask

  // one clock: predict, check enables, push, edge, pop and compare
  task automatic cyc();
    ex_t  nx, exp;
    logic lu, ef, ewe, np;
    lu = m.v & m.mr & m.rw & (m.wr != 0) & ID_valid
       & ((ID_UseRs & (ID_Rs == m.wr)) | (ID_UseRt & (ID_Rt == m.wr)));
    ef = Flush | pend;
    ewe = 1; np = pend; nx = m;
    if (rst) begin
      nx = '0; np = 0; sc = 0; fc = 0;
    end else if (Mem_Busy) begin
      ewe = 0; np = pend | Flush;
    end else if (ef) begin
      nx = '0; np = 0;
      if (fc < 65535) fc++;
    end else if (lu) begin
      nx = '0; ewe = 0;
      if (sc < 65535) sc++;
    end else begin
      nx = {ID_valid, ID_Rs, ID_Rt, ID_WR, ID_RegWrite, ID_MemRead,
            ID_MemWrite, ID_Ctrl, ID_RD1, ID_RD2, ID_Imm};
    end
    q.push_back(nx);
    #1;
    if (!rst) begin
      n_vec++;
      if ({PC_Write, IF_ID_Write} !== {ewe, ewe}) begin
        n_err++;
        $display("FAIL write_en: got %b%b expected %b%b",
                 PC_Write, IF_ID_Write, ewe, ewe);
      end
    end
    last_we = PC_Write;
    @(posedge clk); #1;
    exp = q.pop_front();
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL ex_reg: got %h expected %h", got, exp);
    end
`ifdef HAZ_STATS_EN
    n_vec++;
    if (Stall_Cnt !== 16'(sc) || Flush_Cnt !== 16'(fc)) begin
      n_err++;
      $display("FAIL stats: got %0d/%0d expected %0d/%0d",
               Stall_Cnt, Flush_Cnt, sc, fc);
    end
`endif
    m = exp; pend = np;
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic ok,
                     input logic [31:0] a, input logic [31:0] b);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, a, b);
    end
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    cyc(); cyc();
    rst = 0;
    #1;
    n_vec++;
    if (got !== ex_t'(0)) begin
      n_err++;
      $display("FAIL reset_ex: got %h expected 0", got);
    end
    n_vec++;
    if ({PC_Write, IF_ID_Write} !== 2'b11) begin
      n_err++;
      $display("FAIL reset_we: got %b%b expected 11", PC_Write, IF_ID_Write);
    end
  endtask

  task automatic test_normal();
    idle();
    set_id(1, 2, 1, 1, 3, 1, 0, 5, 7);
    cyc();
    n_vec++;
    if ({EX_valid, EX_WR, EX_RD1, EX_RD2, last_we}
        !== {1'b1, 5'd3, 32'd5, 32'd7, 1'b1}) begin
      n_err++;
      $display("FAIL add_load: got v%b wr%0d rd1 %0d rd2 %0d we%b expected v1 wr3 rd1 5 rd2 7 we1",
               EX_valid, EX_WR, EX_RD1, EX_RD2, last_we);
    end
  endtask

  task automatic test_load_use();
    int s0;
    s0 = sc;
    idle();
    set_id(2, 0, 1, 0, 4, 1, 1, 0, 0);
    cyc();
    set_id(4, 1, 1, 1, 5, 1, 0, 9, 1);
    cyc();
    chk("lu_stall_we", last_we === 1'b0, 32'(last_we), 0);
    chk("lu_bubble", {EX_valid, EX_RegWrite} === 2'b00,
        32'({EX_valid, EX_RegWrite}), 0);
    cyc();
    chk("lu_no_2nd", last_we === 1'b1, 32'(last_we), 1);
    chk("lu_add_ex", {EX_valid, EX_WR} === {1'b1, 5'd5},
        32'({EX_valid, EX_WR}), 32'({1'b1, 5'd5}));
`ifdef HAZ_STATS_EN
    chk("lu_stall_cnt", Stall_Cnt === 16'(s0 + 1),
        32'(Stall_Cnt), 32'(s0 + 1));
`endif
  endtask

  task automatic test_zero_reg();
    idle();
    set_id(1, 0, 1, 0, 0, 1, 1, 0, 0);
    cyc();
    set_id(0, 0, 1, 1, 6, 1, 0, 1, 2);
    cyc();
    chk("r0_no_stall", {last_we, EX_valid} === 2'b11,
        32'({last_we, EX_valid}), 3);
    set_id(2, 0, 1, 0, 4, 1, 1, 0, 0);
    cyc();
    set_id(1, 4, 1, 0, 7, 1, 0, 3, 4);
    cyc();
    chk("urt_mask", {last_we, EX_valid} === 2'b11,
        32'({last_we, EX_valid}), 3);
  endtask

  task automatic test_flush_lu();
    int s0;
    s0 = sc;
    idle();
    set_id(2, 0, 1, 0, 4, 1, 1, 0, 0);
    cyc();
    set_id(4, 1, 1, 1, 5, 1, 0, 1, 1);
    Flush = 1;
    cyc();
    Flush = 0;
    chk("flu_we", last_we === 1'b1, 32'(last_we), 1);
    chk("flu_bubble", EX_valid === 1'b0, 32'(EX_valid), 0);
    chk("flu_stall_cnt", sc == s0, sc, s0);
  endtask

  task automatic test_busy();
    ex_t frz;
    idle();
    set_id(1, 2, 1, 1, 8, 1, 0, 11, 12);
    cyc();
    frz = got;
    Mem_Busy = 1;
    set_id(3, 4, 1, 1, 9, 1, 0, 13, 14);
    cyc();
    chk("busy_frz1", got === frz && last_we === 1'b0, 32'(EX_WR), 32'(frz.wr));
    Flush = 1;
    cyc();
    Flush = 0;
    chk("busy_frz2", got === frz && last_we === 1'b0, 32'(EX_WR), 32'(frz.wr));
    cyc();
    chk("busy_frz3", got === frz && last_we === 1'b0, 32'(EX_WR), 32'(frz.wr));
    Mem_Busy = 0;
    cyc();
    chk("busy_pend_bubble", EX_valid === 1'b0 && last_we === 1'b1,
        32'({EX_valid, last_we}), 1);
    cyc();
    chk("busy_resume", EX_WR === 5'd9 && EX_valid === 1'b1,
        32'(EX_WR), 9);
  endtask

  task automatic test_rst_hold();
    idle();
    set_id(1, 2, 1, 1, 10, 1, 0, 1, 2);
    cyc();
    Mem_Busy = 1; Flush = 1;
    cyc();
    Flush = 0; rst = 1;
    cyc();
    rst = 0; Mem_Busy = 0;
    chk("rst_hold_ex", got === ex_t'(0), 32'(EX_WR), 0);
    set_id(3, 1, 1, 1, 11, 1, 0, 21, 22);
    cyc();
    chk("rst_hold_load", EX_valid === 1'b1 && EX_WR === 5'd11,
        32'(EX_WR), 11);
  endtask

  task automatic test_random();
    idle();
    for (int i = 0; i < 400; i++) begin
      ID_valid = ($urandom_range(0, 7) != 0);
      ID_Rs = 5'($urandom_range(0, 3));
      ID_Rt = 5'($urandom_range(0, 3));
      ID_UseRs = 1'($urandom);
      ID_UseRt = 1'($urandom);
      ID_WR = 5'($urandom_range(0, 3));
      ID_RegWrite = ($urandom_range(0, 3) != 0);
      ID_MemRead = 1'($urandom);
      ID_MemWrite = 1'($urandom);
      ID_Ctrl = 8'($urandom);
      ID_RD1 = $urandom; ID_RD2 = $urandom; ID_Imm = $urandom;
      Flush = ($urandom_range(0, 7) == 0);
      Mem_Busy = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 63) == 0);
      cyc();
    end
    idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_err = 0;
    m = '0; pend = 0; sc = 0; fc = 0; last_we = 0;
    idle();
    @(negedge clk);
    test_reset();
    test_normal();
    test_load_use();
    test_zero_reg();
    test_flush_lu();
    test_busy();
    test_rst_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
